ext_bus_arbiter: RTL and testbench
==================================

# ext_bus_arbiter

Shares the MCU external memory/peripheral bus (PIN_ADDR_BUS, PIN_DATA_BUS, PIN_RDN, PIN_WR0N, PIN_WR1N) between two requesters: port A (CPU fetch/load/store) and port B (DMA/debug loader). The block arbitrates, then sequences each transfer through address setup, a strobe phase with programmable wait states, and a hold phase. It sits between the CPU core and the pad ring inside `mcu`.

## Interface
- WAIT_STATES, 1: extra strobe-low cycles per transfer, range 0–15.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- A_REQ / B_REQ  in  1  transfer request, level-sensitive, held with command until ACK.
- A_WR / B_WR  in  1  1 = write, 0 = read.
- A_BE / B_BE  in  2  byte enables for writes: bit0 → WR0N (low byte), bit1 → WR1N.
- A_ADDR / B_ADDR  in  16  word address.
- A_WDATA / B_WDATA  in  16  write data.
- A_GNT / B_GNT  out  1  high from SETUP through HOLD for granted port.
- A_ACK / B_ACK  out  1  one-cycle completion pulse.
- RDATA  out  16  read data register, shared by both ports, valid when ACK is high.
- BUS_ADDR  out  16  to PIN_ADDR_BUS.
- BUS_WDATA  out  16  to PIN_DATA_BUS output driver.
- BUS_OE  out  1  data pad output enable.
- BUS_RDN, BUS_WR0N, BUS_WR1N  out  1  active-low strobes.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: if any REQ high, select winner, latch its ADDR/WR/BE/WDATA into internal registers, → SETUP. Else stay.
- SETUP (1 cycle): BUS_ADDR driven from latch; strobes high; BUS_OE = WR. → STROBE, wait counter loaded with WAIT_STATES.
- STROBE (WAIT_STATES+1 cycles): read: BUS_RDN low. Write: BUS_WR0N = ~BE[0], BUS_WR1N = ~BE[1]. Counter decrements; at zero, read captures PIN data into RDATA on that edge, → HOLD.
- HOLD (1 cycle): strobes high; address and BUS_OE held; granted port ACK high. → IDLE.
- Write with BE = 00: full sequence runs, no write strobe asserts, ACK still returned.
- Read ignores BE; BUS_OE stays low throughout.
- Back-to-back: REQ still high in the IDLE cycle after ACK starts a new transfer; otherwise bus idle.
- Command inputs are sampled only in IDLE; changes during a transfer have no effect.
- RDATA holds last read value until next read completes; writes do not alter it.

## Timing
- Reset values: state IDLE, GNT/ACK 0, BUS_OE 0, all strobes 1, BUS_ADDR 0, BUS_WDATA 0, RDATA 0, round-robin pointer = B (so A wins first tie).
- Latency REQ-seen-in-IDLE to ACK: WAIT_STATES + 3 cycles; bus occupancy per transfer WAIT_STATES + 4 cycles including IDLE.
- Strobe edges are registered outputs; no glitches, address stable one cycle before and one cycle after every strobe.
- RESET mid-transfer: next edge forces reset values, aborts without ACK; requester must reissue.
- REQ dropped mid-transfer: transfer still completes and ACKs.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous A_REQ and B_REQ in IDLE, grant port not served last; pointer updates on every grant.
- Undefined: fixed priority, A always wins ties; B served only when A_REQ low in IDLE; no pointer register.
- Single requests behave identically in both builds.

## Test plan
- Reset: hold RESET 2 cycles mid-STROBE -> strobes 1, BUS_OE 0, no ACK, state IDLE, RDATA 0000.
- Single read, WAIT_STATES=1, A_ADDR=0x1234, bus data 0xBEEF -> BUS_RDN low exactly 2 cycles, A_ACK at cycle 4 after REQ, RDATA=0xBEEF.
- Byte write B_ADDR=0x0040, B_WDATA=0xA55A, B_BE=10 -> BUS_WR1N low 2 cycles, BUS_WR0N stays 1, BUS_OE high SETUP..HOLD, B_ACK once.
- WAIT_STATES=0 back-to-back A reads with REQ held -> each ACK 3 cycles after IDLE, one IDLE cycle between transfers.
- Simultaneous A_REQ and B_REQ held for 4 transfers -> with ARB_ROUND_ROBIN_EN grants A,B,A,B; without, A,A,A,A and B starves until A_REQ drops.
- Write BE=00 -> no strobe asserts, ACK still issued after WAIT_STATES+3 cycles.

Source files
------------

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: two-port arbiter and sequencer for the MCU external memory/peripheral bus.
// Each transfer runs SETUP, then STROBE for WAIT_STATES+1 cycles, then HOLD, then returns to IDLE.
// Ports:
//   clk_i, reset_i                      clock and synchronous active-high reset
//   a_*_i / b_*_i                       requester commands (req, wr, be, addr, wdata)
//   a_gnt_o / b_gnt_o, a_ack_o / b_ack_o  grant (SETUP..HOLD) and one-cycle completion pulse
//   rdata_o                             last captured read data, shared by both ports
//   bus_rdata_i                         data returned on the pin data bus during reads
//   bus_addr_o, bus_wdata_o, bus_oe_o   pad address, write data and data output enable
//   bus_rdn_o, bus_wr0n_o, bus_wr1n_o   active-low read and byte write strobes
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port A has fixed priority.
module ext_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        a_req_i,
  input  logic        a_wr_i,
  input  logic [1:0]  a_be_i,
  input  logic [15:0] a_addr_i,
  input  logic [15:0] a_wdata_i,
  input  logic        b_req_i,
  input  logic        b_wr_i,
  input  logic [1:0]  b_be_i,
  input  logic [15:0] b_addr_i,
  input  logic [15:0] b_wdata_i,
  input  logic [15:0] bus_rdata_i,
  output logic        a_gnt_o,
  output logic        b_gnt_o,
  output logic        a_ack_o,
  output logic        b_ack_o,
  output logic [15:0] rdata_o,
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_wdata_o,
  output logic        bus_oe_o,
  output logic        bus_rdn_o,
  output logic        bus_wr0n_o,
  output logic        bus_wr1n_o
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d, wr_q, wr_d, win_b, busy_d, strobe_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        a_gnt_q, b_gnt_q, a_ack_q, b_ack_q, oe_q, rdn_q, wr0n_q, wr1n_q;
`ifdef ARB_ROUND_ROBIN_EN
  // last_q = 1 means B was served last, so A wins the next tie
  logic        last_q, last_d;
  assign win_b  = b_req_i & (~a_req_i | ~last_q);
  assign last_d = (state_q == IDLE && (a_req_i | b_req_i)) ? win_b : last_q;
  always_ff @(posedge clk_i)
    if (reset_i) last_q <= 1'b1;
    else last_q <= last_d;
`else
  assign win_b = b_req_i & ~a_req_i;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (a_req_i | b_req_i) begin
        state_d = SETUP;
        sel_d   = win_b;
        wr_d    = win_b ? b_wr_i : a_wr_i;
        be_d    = win_b ? b_be_i : a_be_i;
        addr_d  = win_b ? b_addr_i : a_addr_i;
        wdata_d = win_b ? b_wdata_i : a_wdata_i;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'(WAIT_STATES);
      end
      STROBE: if (cnt_q == 4'd0) begin
        state_d = HOLD;
        rdata_d = wr_q ? rdata_q : bus_rdata_i;
      end else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from next-state so every strobe edge comes straight off a flop
  assign busy_d   = state_d != IDLE;
  assign strobe_d = state_d == STROBE;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      oe_q    <= 1'b0;
      rdn_q   <= 1'b1;
      wr0n_q  <= 1'b1;
      wr1n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      a_gnt_q <= busy_d & ~sel_d;
      b_gnt_q <= busy_d & sel_d;
      a_ack_q <= (state_d == HOLD) & ~sel_d;
      b_ack_q <= (state_d == HOLD) & sel_d;
      oe_q    <= busy_d & wr_d;
      rdn_q   <= ~(strobe_d & ~wr_d);
      wr0n_q  <= ~(strobe_d & wr_d & be_d[0]);
      wr1n_q  <= ~(strobe_d & wr_d & be_d[1]);
    end
  assign a_gnt_o     = a_gnt_q;
  assign b_gnt_o     = b_gnt_q;
  assign a_ack_o     = a_ack_q;
  assign b_ack_o     = b_ack_q;
  assign rdata_o     = rdata_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_oe_o    = oe_q;
  assign bus_rdn_o   = rdn_q;
  assign bus_wr0n_o  = wr0n_q;
  assign bus_wr1n_o  = wr1n_q;
endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter: directed checks of ext_bus_arbiter with WAIT_STATES=1 (u[0]) and WAIT_STATES=0 (u[1]).
module tb_ext_bus_arbiter;
  logic        clk, rst;
  logic        a_req, a_wr, b_req, b_wr;
  logic [1:0]  a_be, b_be;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata, bus_rdata;
  logic        a_gnt[2], b_gnt[2], a_ack[2], b_ack[2], bus_oe[2], bus_rdn[2], bus_wr0n[2], bus_wr1n[2];
  logic [15:0] rdata[2], bus_addr[2], bus_wdata[2];
  int          checks = 0, errors = 0;
  int          n_rdn, n_wr0, n_wr1, n_oe, n_gnt, n_acka, n_ackb, n_acks, ack1, ack2, n_badaddr;
  logic [3:0]  seq;
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    ext_bus_arbiter #(.WAIT_STATES(g == 0 ? 1 : 0)) u (
      .clk_i(clk), .reset_i(rst),
      .a_req_i(a_req), .a_wr_i(a_wr), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .b_req_i(b_req), .b_wr_i(b_wr), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .bus_rdata_i(bus_rdata),
      .a_gnt_o(a_gnt[g]), .b_gnt_o(b_gnt[g]), .a_ack_o(a_ack[g]), .b_ack_o(b_ack[g]),
      .rdata_o(rdata[g]), .bus_addr_o(bus_addr[g]), .bus_wdata_o(bus_wdata[g]), .bus_oe_o(bus_oe[g]),
      .bus_rdn_o(bus_rdn[g]), .bus_wr0n_o(bus_wr0n[g]), .bus_wr1n_o(bus_wr1n[g])
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Runs n cycles observing instance k; drop_at=0 releases requests on the first ACK,
  // otherwise requests are released (and A's address scrambled) after cycle drop_at.
  task automatic watch(input int k, input int n, input int drop_at, input logic [15:0] want_addr);
    n_rdn = 0; n_wr0 = 0; n_wr1 = 0; n_oe = 0; n_gnt = 0; n_acka = 0; n_ackb = 0;
    n_acks = 0; ack1 = 0; ack2 = 0; n_badaddr = 0; seq = 4'b0000;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (!bus_rdn[k]) n_rdn++;
      if (!bus_wr0n[k]) n_wr0++;
      if (!bus_wr1n[k]) n_wr1++;
      if (bus_oe[k]) n_oe++;
      if (a_gnt[k] | b_gnt[k]) n_gnt++;
      if ((a_gnt[k] | b_gnt[k]) && bus_addr[k] !== want_addr) n_badaddr++;
      if (a_ack[k]) n_acka++;
      if (b_ack[k]) n_ackb++;
      if (a_ack[k] | b_ack[k]) begin
        n_acks++;
        seq = {seq[2:0], b_ack[k]};
        if (n_acks == 1) ack1 = i;
        else if (n_acks == 2) ack2 = i;
        if (drop_at == 0) begin a_req = 1'b0; b_req = 1'b0; end
      end
      if (i == drop_at) begin a_req = 1'b0; b_req = 1'b0; a_addr = 16'hFFFF; end
    end
  endtask
  initial begin
    rst = 1'b1; a_req = 0; b_req = 0; a_wr = 0; b_wr = 0; a_be = 0; b_be = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0; bus_rdata = 0;
    step(2);
    check("rst_gnt", {a_gnt[0], b_gnt[0], a_ack[0], b_ack[0]}, 0);
    check("rst_strobes", {bus_rdn[0], bus_wr0n[0], bus_wr1n[0], bus_oe[0]}, 4'b1110);
    check("rst_regs", {bus_addr[0], rdata[0]}, 0);
    check("rst_wdata", bus_wdata[0], 0);
    rst = 1'b0;
    a_req = 1; a_wr = 0; a_addr = 16'h1234; bus_rdata = 16'hBEEF;
    watch(0, 6, 0, 16'h1234);
    check("rd_rdn_cycles", n_rdn, 2);
    check("rd_ack_cycle", ack1, 4);
    check("rd_acks", {n_acka[7:0], n_ackb[7:0]}, 16'h0100);
    check("rd_rdata", rdata[0], 16'hBEEF);
    check("rd_no_oe_wr", {n_oe[7:0], n_wr0[7:0], n_wr1[7:0]}, 0);
    check("rd_addr_stable", n_badaddr, 0);
    step(4);
    b_req = 1; b_wr = 1; b_addr = 16'h0040; b_wdata = 16'hA55A; b_be = 2'b10; bus_rdata = 16'h1111;
    watch(0, 6, 0, 16'h0040);
    check("bw_wr1_cycles", n_wr1, 2);
    check("bw_wr0_cycles", n_wr0, 0);
    check("bw_rdn_cycles", n_rdn, 0);
    check("bw_oe_cycles", n_oe, 4);
    check("bw_acks", {n_acka[7:0], n_ackb[7:0]}, 16'h0001);
    check("bw_wdata", bus_wdata[0], 16'hA55A);
    check("bw_rdata_kept", rdata[0], 16'hBEEF);
    step(4);
    a_req = 1; a_wr = 0; a_addr = 16'h0100; bus_rdata = 16'hCAFE;
    watch(1, 8, -1, 16'h0100);
    check("b2b_ack1", ack1, 3);
    check("b2b_ack2", ack2, 7);
    check("b2b_gnt_cycles", n_gnt, 6);
    check("b2b_rdn_cycles", n_rdn, 2);
    check("b2b_rdata", rdata[1], 16'hCAFE);
    a_req = 0;
    step(8);
    a_req = 1; a_wr = 0; a_addr = 16'h0200;
    step(2);
    check("mid_strobe_rdn", bus_rdn[0], 0);
    rst = 1; a_req = 0;
    step(2);
    check("mr_strobes", {bus_rdn[0], bus_wr0n[0], bus_wr1n[0], bus_oe[0]}, 4'b1110);
    check("mr_gnt_ack", {a_gnt[0], b_gnt[0], a_ack[0], b_ack[0]}, 0);
    check("mr_rdata", rdata[0], 0);
    rst = 0;
    watch(0, 4, -1, 16'h0000);
    check("mr_no_ack_after", n_acks + n_gnt, 0);
    a_req = 1; b_req = 1; a_wr = 0; b_wr = 0; a_addr = 16'h0300; b_addr = 16'h0300; bus_rdata = 16'h7777;
    watch(0, 20, -1, 16'h0300);
    check("tie_acks", n_acks, 4);
`ifdef ARB_ROUND_ROBIN_EN
    check("tie_seq", seq, 4'b0101);
`else
    check("tie_seq", seq, 4'b0000);
`endif
    a_req = 0;
    watch(0, 6, 0, 16'h0300);
    check("b_after_a_ack", ack1, 4);
    check("b_after_a_who", {n_acka[7:0], n_ackb[7:0]}, 16'h0001);
    step(4);
    bus_rdata = 16'h9999;
    a_req = 1; a_wr = 1; a_be = 2'b00; a_addr = 16'h0555; a_wdata = 16'h1234;
    watch(0, 6, 0, 16'h0555);
    check("be0_strobes", n_rdn + n_wr0 + n_wr1, 0);
    check("be0_ack_cycle", ack1, 4);
    check("be0_oe_cycles", n_oe, 4);
    check("be0_wdata", bus_wdata[0], 16'h1234);
    step(4);
    a_req = 1; a_wr = 1; a_be = 2'b11; a_addr = 16'h0AAA; a_wdata = 16'h5555;
    watch(0, 6, 2, 16'h0AAA);
    check("drop_ack_cycle", ack1, 4);
    check("drop_addr_held", n_badaddr, 0);
    check("drop_wr_cycles", {n_wr0[7:0], n_wr1[7:0]}, 16'h0202);
    check("drop_wdata", bus_wdata[0], 16'h5555);
    check("rdata_kept_writes", rdata[0], 16'h7777);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
